// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into {ext, brk, code} events and pushes them to the key FIFO.
// Optional feature: define KEY_CTRL_REPEAT_FILTER_EN to suppress typematic repeats of the last make code.
module ps2_key_ctrl #(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int CNT_W          = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] dout,
   input  logic       fifo_full,
   output logic       wr_en,
   output logic [9:0] wr_data,
   output logic       rx_en,
   output logic       err_tick,
   output logic       ovf_tick
);

   typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, PUSH} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [9:0]       hold_reg;
   logic             err_reg;
   logic             ovf_reg;

   logic       bad_byte;
   logic       in_prefix;
   logic       ev_ext;
   logic       ev_brk;
   logic [9:0] ev_word;
   logic       suppress;
   logic       write;

   assign bad_byte  = (dout == 8'h00) || (dout == 8'hFF);
   assign in_prefix = (state_reg == GOT_E0) || (state_reg == GOT_F0) || (state_reg == GOT_E0F0);
   assign ev_ext    = (state_reg == GOT_E0) || (state_reg == GOT_E0F0);
   assign ev_brk    = (state_reg == GOT_F0) || (state_reg == GOT_E0F0);
   assign ev_word   = {ev_ext, ev_brk, dout};
   assign write     = (state_reg == PUSH) && !fifo_full;

`ifdef KEY_CTRL_REPEAT_FILTER_EN
   logic       last_valid_reg;
   logic       last_ext_reg;
   logic [7:0] last_code_reg;

   assign suppress = !ev_brk && last_valid_reg && (last_ext_reg == ev_ext) && (last_code_reg == dout);

   // The filter tracks what actually reached the FIFO, so it is updated on the write cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_valid_reg <= 1'b0;
         last_ext_reg   <= 1'b0;
         last_code_reg  <= 8'h00;
      end else if (write) begin
         if (!hold_reg[8]) begin
            last_valid_reg <= 1'b1;
            last_ext_reg   <= hold_reg[9];
            last_code_reg  <= hold_reg[7:0];
         end else if (last_valid_reg && (last_ext_reg == hold_reg[9]) && (last_code_reg == hold_reg[7:0])) begin
            last_valid_reg <= 1'b0;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         hold_reg  <= 10'h000;
         err_reg   <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         ovf_reg <= 1'b0;
         if (state_reg == PUSH) begin
            if (rx_done_tick)
               ovf_reg <= 1'b1;
            if (!fifo_full)
               state_reg <= IDLE;
         end else if (rx_done_tick) begin
            // A received byte always takes priority over a timeout in the same cycle.
            cnt_reg <= '0;
            if (bad_byte) begin
               err_reg   <= 1'b1;
               state_reg <= IDLE;
            end else if (state_reg == IDLE && dout == 8'hE0) begin
               state_reg <= GOT_E0;
            end else if (state_reg == IDLE && dout == 8'hF0) begin
               state_reg <= GOT_F0;
            end else if (state_reg == GOT_E0 && dout == 8'hF0) begin
               state_reg <= GOT_E0F0;
            end else if (suppress) begin
               state_reg <= IDLE;
            end else begin
               hold_reg  <= ev_word;
               state_reg <= PUSH;
            end
         end else if (in_prefix) begin
            if (cnt_reg == CNT_LAST) begin
               err_reg   <= 1'b1;
               state_reg <= IDLE;
               cnt_reg   <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

   assign wr_en    = write;
   assign wr_data  = hold_reg;
   assign rx_en    = (state_reg != PUSH);
   assign err_tick = err_reg;
   assign ovf_tick = ovf_reg;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a byte-level reference model queues expected writes, errors and drops.
module tb_ps2_key_ctrl;
   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_done_tick = 1'b0;
   logic [7:0] dout = 8'h00;
   logic       fifo_full = 1'b0;
   logic       wr_en;
   logic [9:0] wr_data;
   logic       rx_en;
   logic       err_tick;
   logic       ovf_tick;

   ps2_key_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .dout(dout),
      .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data), .rx_en(rx_en),
      .err_tick(err_tick), .ovf_tick(ovf_tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   logic [9:0] wr_q[$];
   bit         err_q[$];
   bit         ovf_q[$];
   bit         rand_mode = 1'b0;

   // reference model state: pending prefixes and last pushed make code
   bit       m_ext = 0, m_brk = 0;
   bit       m_last_valid = 0;
   bit [8:0] m_last = 9'h000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_event(input bit ext, input bit brk, input bit [7:0] code);
      bit push = 1;
`ifdef KEY_CTRL_REPEAT_FILTER_EN
      if (!brk) begin
         if (m_last_valid && m_last == {ext, code}) push = 0;
         else begin m_last_valid = 1; m_last = {ext, code}; end
      end else if (m_last_valid && m_last == {ext, code}) begin
         m_last_valid = 0;
      end
`endif
      if (push) wr_q.push_back({ext, brk, code});
   endtask

   task automatic model_byte(input bit [7:0] b);
      if (b == 8'h00 || b == 8'hFF) begin
         err_q.push_back(1'b1);
         m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0 && !m_ext && !m_brk) begin
         m_ext = 1;
      end else if (b == 8'hF0 && !m_brk) begin
         m_brk = 1;
      end else begin
         model_event(m_ext, m_brk, b);
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Idle for n cycles; a long enough silence after a prefix must time out.
   task automatic wait_idle(input int n);
      if (n > T + 2 && (m_ext || m_brk)) begin
         err_q.push_back(1'b1);
         m_ext = 0; m_brk = 0;
      end
      repeat (n) step();
   endtask

   task automatic send(input bit [7:0] b);
      int guard = 0;
      while (!rx_en && guard < 500) begin
         if (rand_mode) fifo_full = ($urandom_range(0, 2) == 0);
         step();
         guard++;
      end
      if (!rx_en) chk("rx_en_wait_timeout", 32'(rx_en), 32'd1);
      dout = b;
      rx_done_tick = 1'b1;
      model_byte(b);
      step();
      rx_done_tick = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) step();
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'h000);
      chk("rst_rx_en", 32'(rx_en), 32'd1);
      chk("rst_err_tick", 32'(err_tick), 32'd0);
      chk("rst_ovf_tick", 32'(ovf_tick), 32'd0);
      reset = 1'b1;
      m_ext = 0; m_brk = 0; m_last_valid = 0;
      step();
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (reset) begin
            if (wr_en) begin
               if (wr_q.size() == 0) chk("unexpected_write", 32'(wr_data), 32'h3FF);
               else chk("wr_data", 32'(wr_data), 32'(wr_q.pop_front()));
            end
            if (err_tick) begin
               if (err_q.size() == 0) chk("unexpected_err_tick", 32'd1, 32'd0);
               else chk("err_tick", 32'(err_q.pop_front()), 32'd1);
            end
            if (ovf_tick) begin
               if (ovf_q.size() == 0) chk("unexpected_ovf_tick", 32'd1, 32'd0);
               else chk("ovf_tick", 32'(ovf_q.pop_front()), 32'd1);
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      do_reset();

      // single make and a break, with write latency of one cycle
      send(8'h1C);
      chk("make_latency_wr_en", 32'(wr_en), 32'd1);
      wait_idle(2);
      send(8'hF0); send(8'h1C);
      chk("break_latency_wr_en", 32'(wr_en), 32'd1);
      wait_idle(2);
      send(8'hE0); send(8'hF0); send(8'h75);
      wait_idle(2);
      send(8'hE0); send(8'h75);
      wait_idle(3);
      $display("directed: basic make/break sequences done");

      // stalled event with a dropped byte
      do_reset();
      fifo_full = 1'b1;
      send(8'h1C);
      chk("stall_rx_en", 32'(rx_en), 32'd0);
      chk("stall_wr_en", 32'(wr_en), 32'd0);
      dout = 8'h32;
      rx_done_tick = 1'b1;
      ovf_q.push_back(1'b1);
      step();
      rx_done_tick = 1'b0;
      repeat (3) step();
      chk("stall_wr_data_stable", 32'(wr_data), 32'h01C);
      chk("stall_rx_en_held", 32'(rx_en), 32'd0);
      fifo_full = 1'b0;
      step();
      chk("unstall_rx_en", 32'(rx_en), 32'd1);
      wait_idle(2);
      $display("directed: stall/overflow done");

      // prefix timeout, then a plain make
      send(8'hF0);
      wait_idle(T + 6);
      send(8'h1C);
      wait_idle(2);
      $display("directed: timeout done");

      // error bytes and reset mid-prefix
      send(8'hFF);
      wait_idle(2);
      send(8'hE0); send(8'h00);
      wait_idle(2);
      send(8'hE0); send(8'hF0);
      do_reset();
      send(8'h1C);
      wait_idle(3);
      $display("directed: error bytes and reset done");

      // repeat-filter sequence (filtered or not, depending on the build)
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C);
      send(8'hF0); send(8'h1C); send(8'h1C);
      wait_idle(3);
      $display("directed: repeat sequence done");

      // randomized bytes, gaps and FIFO back-pressure
      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bit [7:0] b;
         case ($urandom_range(0, 9))
            0, 1: b = 8'hE0;
            2, 3: b = 8'hF0;
            4:    b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
            5:    b = 8'h1C;
            6:    b = 8'h75;
            default: b = 8'($urandom_range(0, 255));
         endcase
         fifo_full = ($urandom_range(0, 3) == 0);
         send(b);
         if ($urandom_range(0, 19) == 0) wait_idle(T + 4);
         else wait_idle($urandom_range(0, 3));
      end
      rand_mode = 1'b0;
      fifo_full = 1'b0;
      wait_idle(20);
      $display("random: 400 bytes sent");

      chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk("err_q_drained", 32'(err_q.size()), 32'd0);
      chk("ovf_q_drained", 32'(ovf_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
